async_fifo_read_ctrl: RTL

//  Read-domain half of the AHB2APB bridge async FIFO, parametrised successor of the fixed-depth reader.

---
 rtl/async_fifo_read_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/async_fifo_read_ctrl.sv
// Read-domain controller of the AHB2APB bridge asynchronous FIFO.
// Brings the write-domain gray pointer across the clock boundary, keeps the
// read pointer, empty/almost-empty, fill level and the sticky underflow flag,
// and presents data either registered or first-word-fall-through.
module async_fifo_read_ctrl #(
    parameter int D_SIZE      = 16,
    parameter int A_SIZE      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1,
    parameter bit FWFT        = 1'b0
) (
    input  logic                             i_r_clk,
    input  logic                             i_r_rst,
    input  logic                             i_r_inc,
    input  logic                             i_clr_err,
    input  logic [A_SIZE:0]                  i_gray_w_ptr,
    input  logic [D_SIZE*(2**A_SIZE)-1:0]    i_mem_data,
    output logic [D_SIZE-1:0]                o_r_data,
    output logic                             o_r_valid,
    output logic                             o_empty,
    output logic                             o_almost_empty,
    output logic [A_SIZE:0]                  o_level,
    output logic                             o_underflow,
    output logic [A_SIZE:0]                  o_gray_r_ptr
);

    localparam logic [A_SIZE:0] AE_LVL = (A_SIZE+1)'(AE_THRESH);

    logic [A_SIZE:0]   wsync_q [SYNC_STAGES];
    logic [A_SIZE:0]   wbin;
    logic [A_SIZE:0]   rbin_q,  rbin_d;
    logic [A_SIZE:0]   rgray_q, rgray_d;
    logic              empty_q, empty_d;
    logic              underflow_q, underflow_d;
    logic              popAccept;
    logic [A_SIZE-1:0] rAddr;
    logic [D_SIZE-1:0] headWord;

    function automatic logic [A_SIZE:0] grayToBin(input logic [A_SIZE:0] g);
        logic [A_SIZE:0] b;
        b[A_SIZE] = g[A_SIZE];
        for (int i = A_SIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Write pointer crosses into the read clock through a plain flop chain.
    always_ff @(posedge i_r_clk or posedge i_r_rst) begin
        if (i_r_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= '0;
            end
        end else begin
            wsync_q[0] <= i_gray_w_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= wsync_q[i-1];
            end
        end
    end

    assign wbin      = grayToBin(wsync_q[SYNC_STAGES-1]);
    assign popAccept = i_r_inc & ~empty_q;
    assign rAddr     = rbin_q[A_SIZE-1:0];
    assign headWord  = i_mem_data[rAddr*D_SIZE +: D_SIZE];

    // Next pointer, flags and sticky underflow; empty compares against the synchronised write pointer.
    always_comb begin
        rbin_d      = rbin_q;
        rgray_d     = rgray_q;
        underflow_d = underflow_q;
        if (popAccept) begin
            rbin_d  = rbin_q + 1'b1;
            rgray_d = rbin_d ^ (rbin_d >> 1);
        end
        empty_d = ((rbin_d ^ (rbin_d >> 1)) == wsync_q[SYNC_STAGES-1]);
        if (i_r_inc && empty_q) begin
            underflow_d = 1'b1;
        end else if (i_clr_err) begin
            underflow_d = 1'b0;
        end
    end

    // Read-side state register.
    always_ff @(posedge i_r_clk or posedge i_r_rst) begin
        if (i_r_rst) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT) begin : gFwft
            // Head word shown directly; blanked while empty so reset and idle read as zero.
            always_comb begin
                o_r_data  = empty_q ? '0 : headWord;
                o_r_valid = ~empty_q;
            end
        end else begin : gReg
            logic [D_SIZE-1:0] rdata_q;
            logic              rvalid_q;

            // Registered output: capture head word on an accepted pop, valid for one cycle.
            always_ff @(posedge i_r_clk or posedge i_r_rst) begin
                if (i_r_rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= popAccept;
                    if (popAccept) begin
                        rdata_q <= headWord;
                    end
                end
            end

            assign o_r_data  = rdata_q;
            assign o_r_valid = rvalid_q;
        end
    endgenerate

    assign o_empty        = empty_q;
    assign o_level        = wbin - rbin_q;
    assign o_almost_empty = (o_level <= AE_LVL);
    assign o_underflow    = underflow_q;
    assign o_gray_r_ptr   = rgray_q;

endmodule
